// File: rtl/sr_pulse_pkg.sv
// rtl/sr_pulse_pkg.sv - shared state encoding and default timing constants for sr_pulse_driver
package sr_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } sr_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES    = 2;

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - 2-FF synchroniser, counting debouncer and rising-edge strobe for one raw input
module sr_debounce
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d    = raw_in;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rise = deb_q & ~deb_prev_q;

endmodule

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - debounced set/reset requests to mutually exclusive s/r pulses; SR_CONFLICT_CNT_EN adds conflict_cnt
module sr_pulse_driver
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             set_in,
  input  logic             reset_in,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

  logic set_req, reset_req;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (set_in),
    .rise   (set_req)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (reset_in),
    .rise   (reset_req)
  );

  sr_state_t     state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;

  // Requests are only looked at in IDLE, so anything arriving mid-pulse is dropped.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (set_req && reset_req) begin
          conflict_d = 1'b1;
        end else if (set_req) begin
          state_d = PULSE_S;
          s_d     = 1'b1;
        end else if (reset_req) begin
          state_d = PULSE_R;
          r_d     = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pcnt_q == P_LAST) begin
          state_d = GAP;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
          s_d    = (state_q == PULSE_S);
          r_d    = (state_q == PULSE_R);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if (conflict_d && (ccnt_q != {CNT_W{1'b1}})) begin
      ccnt_d = ccnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
    end
  end

  assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - directed self-checking bench for sr_pulse_driver
module tb_sr_pulse_driver;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic set_in = 1'b0;
  logic reset_in = 1'b0;
  logic s, r, busy, conflict;
  int   total = 0;
  int   bad = 0;

`ifdef SR_CONFLICT_CNT_EN
  logic [1:0] conflict_cnt;
  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .set_in(set_in), .reset_in(reset_in),
    .s(s), .r(r), .busy(busy), .conflict(conflict), .conflict_cnt(conflict_cnt)
  );
`else
  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .set_in(set_in), .reset_in(reset_in),
    .s(s), .r(r), .busy(busy), .conflict(conflict)
  );
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n) chk("s_and_r", {31'd0, s & r}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nhigh;
    tick(2);
    chk("rst_s", s, 0); chk("rst_r", r, 0); chk("rst_busy", busy, 0); chk("rst_conflict", conflict, 0);
`ifdef SR_CONFLICT_CNT_EN
    chk("rst_cnt", 32'(conflict_cnt), 0);
`endif
    reset_n = 1'b1;
    tick(2);

    // 1: clean set -> s high after edge 7 for 2 cycles, busy for 3
    set_in = 1'b1;
    tick(6); chk("t1_s_e6", s, 0); chk("t1_busy_e6", busy, 0);
    tick(1); chk("t1_s_e7", s, 1); chk("t1_r_e7", r, 0); chk("t1_busy_e7", busy, 1);
    tick(1); chk("t1_s_e8", s, 1); chk("t1_r_e8", r, 0); chk("t1_busy_e8", busy, 1);
    tick(1); chk("t1_s_e9", s, 0); chk("t1_busy_e9", busy, 1);
    tick(1); chk("t1_s_e10", s, 0); chk("t1_busy_e10", busy, 0);
    set_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1); chk("t1_fall_s", s, 0); chk("t1_fall_busy", busy, 0);
    end

    // 2: three-cycle glitch is rejected
    set_in = 1'b1;
    tick(3);
    set_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1); chk("t2_s", s, 0); chk("t2_busy", busy, 0);
    end

    // 3: simultaneous requests -> one conflict pulse, no s/r
    set_in = 1'b1; reset_in = 1'b1;
    tick(6); chk("t3_conf_e6", conflict, 0);
    tick(1); chk("t3_conf_e7", conflict, 1); chk("t3_s", s, 0); chk("t3_r", r, 0); chk("t3_busy", busy, 0);
`ifdef SR_CONFLICT_CNT_EN
    chk("t3_cnt", 32'(conflict_cnt), 1);
`endif
    tick(1); chk("t3_conf_e8", conflict, 0); chk("t3_busy_e8", busy, 0);
    set_in = 1'b0; reset_in = 1'b0;
    tick(8);

    // 4: set arriving during an r pulse is dropped
    reset_in = 1'b1;
    tick(2);
    set_in = 1'b1;
    tick(5); chk("t4_r_e7", r, 1); chk("t4_s_e7", s, 0);
    tick(1); chk("t4_r_e8", r, 1); chk("t4_s_e8", s, 0);
    tick(1); chk("t4_r_e9", r, 0); chk("t4_busy_e9", busy, 1);
    tick(1); chk("t4_busy_e10", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1); chk("t4_s_drop", s, 0); chk("t4_busy_drop", busy, 0);
    end
    set_in = 1'b0; reset_in = 1'b0;
    tick(8);

    // 5: async reset in second cycle of an s pulse
    set_in = 1'b1;
    tick(7); chk("t5_s_e7", s, 1);
    tick(1); chk("t5_s_e8", s, 1);
    set_in = 1'b0; reset_n = 1'b0;
    #1; chk("t5_s_async", s, 0); chk("t5_busy_async", busy, 0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1); chk("t5_s_after", s, 0); chk("t5_busy_after", busy, 0);
    end

    // 7: input held high through reset release -> exactly one pulse
    set_in = 1'b1; reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6); chk("t7_s_e6", s, 0);
    tick(1); chk("t7_s_e7", s, 1);
    nhigh = 1;
    for (int i = 0; i < 12; i++) begin
      tick(1); nhigh += int'(s);
    end
    chk("t7_count", nhigh, 2);
    set_in = 1'b0;
    tick(8);

    // 6: five conflicts, counter saturates at 3 with CNT_W=2
    for (int k = 0; k < 5; k++) begin
      set_in = 1'b1; reset_in = 1'b1;
      tick(7); chk("t6_conf", conflict, 1); chk("t6_s", s, 0); chk("t6_r", r, 0);
`ifdef SR_CONFLICT_CNT_EN
      chk("t6_cnt", 32'(conflict_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
`endif
      set_in = 1'b0; reset_in = 1'b0;
      tick(8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
